dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder serving the MEM stage's load/store requests. It accepts one request at a time, models a word-organised synchronous SRAM with a programmable number of wait states, and performs byte-lane write merging. It returns right-aligned read data for the MEM stage's load extender and drives the stall signal that the MEM stage uses as `hold_flag_mem`. It is the memory-side end of the MEM-stage data-access interface.

## Interface
Parameters:
- `ADDR_WIDTH`, 14: word-address bits; depth is 2^ADDR_WIDTH words. Byte address bits [ADDR_WIDTH+1:2] index the array; higher bits are ignored, so accesses wrap.
- `WAIT_CYCLES`, 1: extra cycles between acceptance and the array access; legal range 0..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  MEM stage presents a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `req_ready`  out  1  responder can accept; high only in IDLE.
- `hold`  out  1  stall request to the MEM stage; feeds `hold_flag_mem`.
- `rsp_valid`  out  1  response available.
- `rsp_rdata`  out  32  load data shifted right by 8*addr[1:0]; upper bits are raw (not extended); 0 for stores and errors.
- `rsp_err`  out  1  misaligned or illegal-size access; qualified by `rsp_valid`.
- `rsp_ready`  in  1  MEM stage consumes the response this cycle.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch we/size/addr/wdata and load the wait counter with WAIT_CYCLES.
  - Go to BUSY if WAIT_CYCLES>0. If WAIT_CYCLES=0, perform the access on this edge and go to RESP.
- BUSY: decrement the counter each cycle. The access executes on the edge where the counter is 0, and the FSM moves to RESP on that edge.
- RESP:
  - `rsp_valid`=1, with `rsp_rdata`/`rsp_err` held stable.
  - On `rsp_ready`=1, go to IDLE. Otherwise stay in RESP with no re-access; a store is never repeated.
- `hold` = (IDLE & `req_valid`) | BUSY. It is 0 in RESP and combinational from `req_valid` in IDLE.
- Alignment:
  - Byte accesses are always legal.
  - Half requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - Size 11 is illegal.
  - Violations follow the normal state/timing path, but the array is not accessed, `rsp_err`=1, and `rsp_rdata`=0.
- Store byte enables:
  - byte: 4'b0001 << addr[1:0].
  - half: 4'b0011 << addr[1:0].
  - word: 4'b1111.
- Store data lanes: byte replicates wdata[7:0] to all four lanes; half replicates wdata[15:0] to both halves. Only enabled bytes change.
- Load: read the full word, then shift right by 8*addr[1:0].
- Request inputs are sampled only at acceptance. Changes to them in BUSY/RESP are ignored.

## Timing
- Reset (async, immediate):
  - state=IDLE, counter=0, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0.
  - Because the state is IDLE, `req_ready`=1 and `hold` follows `req_valid`.
  - Array contents are not reset.
- Acceptance in cycle T gives `rsp_valid`=1 first in cycle T+WAIT_CYCLES+1. `hold` is high in cycles T..T+WAIT_CYCLES.
- Earliest back-to-back operation: response consumed in cycle R, next request accepted in R+1.
- A store followed by a load to the same word returns the merged data; there is no forwarding path and none is needed.
- Reset asserted in BUSY or RESP aborts the transaction. If the array write has not yet occurred, it is lost.
- `rsp_ready` outside RESP is ignored.

## Test plan
- Reset mid-BUSY (WAIT_CYCLES=3, store in flight) -> state IDLE and outputs 0 at once; the word's old value is retained.
- WAIT_CYCLES=1:
  - Store word 0x11223344 to 0x100, then load byte at 0x102 -> `hold` high for 2 cycles.
  - `rsp_valid` appears in cycle T+2.
  - `rsp_rdata`[7:0]=0x22, `rsp_err`=0.
- Store half 0xBEEF to 0x106 over word 0x0 -> word 0x104 reads back 0xBEEF0000. Then store byte 0xA5 to 0x105 -> word reads 0xBEEFA500.
- Load word from 0x102 -> `rsp_err`=1, `rsp_rdata`=0, memory unchanged. Store size 11 -> `rsp_err`=1, no write.
- Store 0xCAFEF00D with `rsp_ready` held low for 5 RESP cycles:
  - `rsp_valid` stays 1 and `req_ready` stays 0.
  - A corrupted `req_wdata` during the wait has no effect.
  - The word is written exactly once.
- WAIT_CYCLES=0 -> load accepted in T gives `rsp_valid` in T+1 and `hold` high only in T.
- Address 0x0004_0000 with ADDR_WIDTH=14 aliases word 0.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one outstanding load/store against a
// word-organised SRAM with programmable wait states and byte-lane store merging.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 14,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        hold,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  input  logic        rsp_ready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int AW    = ADDR_WIDTH + 2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q;

  logic            lat_we;
  logic [1:0]      lat_size;
  logic [AW-1:0]   lat_addr;
  logic [31:0]     lat_wdata;

  logic            acc_we;
  logic [1:0]      acc_size;
  logic [AW-1:0]   acc_addr;
  logic [31:0]     acc_wdata;
  logic            acc_err;
  logic [3:0]      acc_be;
  logic [31:0]     acc_lanes;
  logic [1:0]      off;
  logic [ADDR_WIDTH-1:0] idx;

  logic            accept;
  logic            access;
  logic            mem_wr;

  // Byte-address bits above the array index are deliberately ignored so accesses wrap.
  logic            unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW];

  logic [31:0] mem [DEPTH];

  assign accept = (state_q == IDLE) && req_valid;

  // With zero wait states the access happens on the acceptance edge itself; otherwise
  // it happens on the edge that takes the BUSY countdown to zero.
  assign access = (accept && (WAIT_CYCLES == 0)) ||
                  ((state_q == BUSY) && (cnt_q == 4'd1));

  // On the acceptance edge the latches are not yet loaded, so the live request is used.
  assign acc_we    = (state_q == IDLE) ? req_we           : lat_we;
  assign acc_size  = (state_q == IDLE) ? req_size         : lat_size;
  assign acc_addr  = (state_q == IDLE) ? req_addr[AW-1:0] : lat_addr;
  assign acc_wdata = (state_q == IDLE) ? req_wdata        : lat_wdata;

  assign off = acc_addr[1:0];
  assign idx = acc_addr[AW-1:2];

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    acc_err   = 1'b0;
    acc_be    = 4'b0000;
    acc_lanes = acc_wdata;
    case (acc_size)
      SZ_BYTE: begin
        acc_be    = 4'b0001 << off;
        acc_lanes = {4{acc_wdata[7:0]}};
      end
      SZ_HALF: begin
        acc_err   = off[0];
        acc_be    = 4'b0011 << off;
        acc_lanes = {2{acc_wdata[15:0]}};
      end
      SZ_WORD: begin
        acc_err   = (off != 2'b00);
        acc_be    = 4'b1111;
      end
      default: acc_err = 1'b1;
    endcase
  end

  assign mem_wr = access && acc_we && !acc_err;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = (WAIT_CYCLES == 0) ? RESP : BUSY;
      BUSY:    if (cnt_q == 4'd1) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign hold      = ((state_q == IDLE) && req_valid) || (state_q == BUSY);
  assign rsp_valid = (state_q == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else if (accept) begin
      cnt_q <= 4'(WAIT_CYCLES);
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // NOTE: request latches and the array hold pure data qualified by the FSM, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= req_we;
      lat_size  <= req_size;
      lat_addr  <= req_addr[AW-1:0];
      lat_wdata <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) mem[idx][8*b +: 8] <= acc_lanes[8*b +: 8];
      end
    end
  end

  // Response registers are loaded only by the access edge, so they stay stable through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else if (access) begin
      rsp_err   <= acc_err;
      rsp_rdata <= (acc_we || acc_err) ? 32'h0 : (mem[idx] >> {off, 3'b000});
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (0, 1 and 3 wait states) checked against
// a byte-level memory model, with directed scenarios followed by random traffic.
module tb_dmem_responder;

  localparam int ND    = 3;
  localparam int WORDS = 16384;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid [ND];
  logic        req_we    [ND];
  logic [1:0]  req_size  [ND];
  logic [31:0] req_addr  [ND];
  logic [31:0] req_wdata [ND];
  logic        rsp_ready [ND];
  wire         req_ready [ND];
  wire         hold      [ND];
  wire         rsp_valid [ND];
  wire  [31:0] rsp_rdata [ND];
  wire         rsp_err   [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    dmem_responder #(
      .ADDR_WIDTH (14),
      .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 1 : 3))
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid[g]),
      .req_we   (req_we[g]),
      .req_size (req_size[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .req_ready(req_ready[g]),
      .hold     (hold[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g]),
      .rsp_ready(rsp_ready[g])
    );
  end

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_mem [ND][WORDS];
  bit          ref_ok  [ND][WORDS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  function automatic bit model_err(input logic [1:0] size, input logic [31:0] addr);
    int n;
    if (size == 2'b11) return 1'b1;
    n = 1 << size;
    return (int'(addr[1:0]) % n) != 0;
  endfunction

  // Bytes addr..addr+n-1 of the word take bytes 0..n-1 of the store data.
  function automatic void model_store(input int d, input logic [1:0] size,
                                      input logic [31:0] addr, input logic [31:0] wdata);
    int w, o, n;
    w = int'(addr[15:2]);
    o = int'(addr[1:0]);
    n = 1 << size;
    for (int k = 0; k < n; k++) ref_mem[d][w][8*(o+k) +: 8] = wdata[8*k +: 8];
    if (n == 4) ref_ok[d][w] = 1'b1;
  endfunction

  task automatic idle_inputs(input int d);
    req_valid[d] = 1'b0;
    req_we[d]    = 1'b0;
    req_size[d]  = 2'b00;
    req_addr[d]  = 32'h0;
    req_wdata[d] = 32'h0;
    rsp_ready[d] = 1'b0;
  endtask

  task automatic txn(input int d, input logic we, input logic [1:0] size,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int stall, input string tag);
    logic [31:0] exp_rd;
    logic        exp_err;
    bit          data_known;
    int          w;
    int          wt;
    wt         = wait_of(d);
    w          = int'(addr[15:2]);
    exp_err    = model_err(size, addr);
    exp_rd     = 32'h0;
    data_known = 1'b1;
    if (!exp_err && !we) begin
      exp_rd     = ref_mem[d][w] >> (8 * int'(addr[1:0]));
      data_known = ref_ok[d][w];
    end
    if (!exp_err && we) model_store(d, size, addr, wdata);

    @(negedge clk);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_size[d]  = size;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    rsp_ready[d] = 1'b0;
    #1;
    check($sformatf("%s.ready_acc", tag), 32'(req_ready[d]), 32'd1);
    check($sformatf("%s.hold_acc", tag), 32'(hold[d]), 32'd1);
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_we[d]    = 1'($urandom);
    req_size[d]  = 2'($urandom);
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;
    for (int c = 1; c <= wt + 1; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("%s.hold_c%0d", tag, c), 32'(hold[d]), 32'(c <= wt));
      check($sformatf("%s.valid_c%0d", tag, c), 32'(rsp_valid[d]), 32'(c == wt + 1));
      check($sformatf("%s.ready_c%0d", tag, c), 32'(req_ready[d]), 32'd0);
    end
    check($sformatf("%s.err", tag), 32'(rsp_err[d]), 32'(exp_err));
    if (data_known) check($sformatf("%s.rdata", tag), rsp_rdata[d], exp_rd);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      #1;
      req_wdata[d] = $urandom;
      check($sformatf("%s.stall_valid%0d", tag, s), 32'(rsp_valid[d]), 32'd1);
      check($sformatf("%s.stall_ready%0d", tag, s), 32'(req_ready[d]), 32'd0);
      check($sformatf("%s.stall_hold%0d", tag, s), 32'(hold[d]), 32'd0);
      if (data_known) check($sformatf("%s.stall_rdata%0d", tag, s), rsp_rdata[d], exp_rd);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[d] = 1'b0;
    check($sformatf("%s.done_ready", tag), 32'(req_ready[d]), 32'd1);
    check($sformatf("%s.done_valid", tag), 32'(rsp_valid[d]), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    for (int d = 0; d < ND; d++) idle_inputs(d);
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("rst.ready%0d", d), 32'(req_ready[d]), 32'd1);
      check($sformatf("rst.valid%0d", d), 32'(rsp_valid[d]), 32'd0);
      check($sformatf("rst.hold%0d", d), 32'(hold[d]), 32'd0);
      check($sformatf("rst.err%0d", d), 32'(rsp_err[d]), 32'd0);
      check($sformatf("rst.rdata%0d", d), rsp_rdata[d], 32'd0);
    end
    req_valid[1] = 1'b1;
    #1;
    check("rst.hold_follows", 32'(hold[1]), 32'd1);
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // One wait state: merging, errors, stalled response, aliasing.
    txn(1, 1'b1, 2'b10, 32'h0000_0100, 32'h1122_3344, 0, "st_w100");
    txn(1, 1'b0, 2'b00, 32'h0000_0102, 32'h0,         0, "ld_b102");
    txn(1, 1'b1, 2'b10, 32'h0000_0104, 32'h0,         0, "st_w104");
    txn(1, 1'b1, 2'b01, 32'h0000_0106, 32'h0000_BEEF, 0, "st_h106");
    txn(1, 1'b0, 2'b10, 32'h0000_0104, 32'h0,         0, "ld_w104a");
    txn(1, 1'b1, 2'b00, 32'h0000_0105, 32'h1234_56A5, 0, "st_b105");
    txn(1, 1'b0, 2'b10, 32'h0000_0104, 32'h0,         0, "ld_w104b");
    txn(1, 1'b0, 2'b10, 32'h0000_0102, 32'h0,         0, "ld_w102_mis");
    txn(1, 1'b1, 2'b11, 32'h0000_0100, 32'hFFFF_FFFF, 0, "st_ill100");
    txn(1, 1'b1, 2'b01, 32'h0000_0101, 32'hFFFF_FFFF, 0, "st_h101_mis");
    txn(1, 1'b0, 2'b10, 32'h0000_0100, 32'h0,         0, "ld_w100");
    txn(1, 1'b0, 2'b01, 32'h0000_0102, 32'h0,         0, "ld_h102");
    txn(1, 1'b1, 2'b10, 32'h0000_0108, 32'hCAFE_F00D, 5, "st_w108_stall");
    txn(1, 1'b0, 2'b10, 32'h0000_0108, 32'h0,         0, "ld_w108");
    txn(1, 1'b1, 2'b10, 32'h0004_0000, 32'hDEAD_BEEF, 0, "st_alias");
    txn(1, 1'b0, 2'b10, 32'h0000_0000, 32'h0,         0, "ld_w000");

    // Zero wait states.
    txn(0, 1'b1, 2'b10, 32'h0000_0040, 32'hA1B2_C3D4, 0, "z_st");
    txn(0, 1'b0, 2'b00, 32'h0000_0043, 32'h0,         1, "z_ld_b");
    txn(0, 1'b0, 2'b10, 32'h0000_0040, 32'h0,         0, "z_ld_w");

    // Three wait states, then reset while a store is in flight.
    txn(2, 1'b1, 2'b10, 32'h0000_0200, 32'h5566_7788, 0, "w3_st");
    txn(2, 1'b0, 2'b10, 32'h0000_0200, 32'h0,         0, "w3_ld");
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_size[2]  = 2'b10;
    req_addr[2]  = 32'h0000_0200;
    req_wdata[2] = 32'h9999_9999;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    #1;
    check("abort.busy_hold", 32'(hold[2]), 32'd1);
    rst = 1'b1;
    #1;
    check("abort.ready", 32'(req_ready[2]), 32'd1);
    check("abort.hold", 32'(hold[2]), 32'd0);
    check("abort.valid", 32'(rsp_valid[2]), 32'd0);
    check("abort.err", 32'(rsp_err[2]), 32'd0);
    check("abort.rdata", rsp_rdata[2], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    txn(2, 1'b0, 2'b10, 32'h0000_0200, 32'h0, 0, "abort.old_word");

    // Random traffic over a small pre-initialised window, with random upper address bits.
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < 16; i++)
        txn(d, 1'b1, 2'b10, 32'h0000_0300 + 32'(4 * i), $urandom, 0, $sformatf("init%0d_%0d", d, i));
      for (int i = 0; i < 60; i++) begin
        a  = 32'h0000_0300 + 32'($urandom_range(0, 63));
        a  = a | ($urandom & 32'hFFFC_0000);
        sz = 2'($urandom_range(0, 3));
        txn(d, 1'($urandom), sz, a, $urandom, int'($urandom_range(0, 3)),
            $sformatf("rnd%0d_%0d", d, i));
      end
      for (int i = 0; i < 16; i++)
        txn(d, 1'b0, 2'b10, 32'h0000_0300 + 32'(4 * i), 32'h0, 0, $sformatf("final%0d_%0d", d, i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
